// File: rtl/shift_controller_pkg.sv
// shift_controller_pkg: FSM state encodings and ShiftRegister mode constants
package shift_controller_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_SHIFT   = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_RSH  = 2'b01;
  localparam logic [1:0] MODE_LSH  = 2'b10;
endpackage

// File: rtl/shift_counter.sv
// shift_counter: remaining-shift down-counter with load, decrement and count flags
module shift_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             is_one_o,
  output logic             is_zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? count_i : dec_i ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign is_one_o  = cnt_q == CNT_W'(1);
  assign is_zero_o = cnt_q == '0;
endmodule

// File: rtl/shift_controller.sv
// shift_controller: sequences an external ShiftRegister through load, N shifts and capture
module shift_controller
  import shift_controller_pkg::*;
#(
  parameter int CNT_W  = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic              cmd_dir_i,
  input  logic [CNT_W-1:0]  cmd_count_i,
  input  logic              abort_i,
  output logic              sr_load_o,
  output logic [1:0]        sr_mode_o,
  output logic [DATA_W-1:0] sr_data_o,
  input  logic [DATA_W-1:0] sr_q_i,
  input  logic              sr_flag_i,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              flag_o,
  output logic              busy_o
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d, result_q, result_d;
  logic              dir_q, dir_d, flag_q, flag_d, done_q, done_d;
  logic              accept, capture, cnt_one, cnt_zero;
  assign accept  = cmd_valid_i && state_q == S_IDLE;
  assign capture = state_q == S_CAPTURE && !abort_i;
  // counter is loaded on accept so LOAD can already branch on a zero count
  shift_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .dec_i    (state_q == S_SHIFT),
    .count_i  (cmd_count_i),
    .is_one_o (cnt_one),
    .is_zero_o(cnt_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = (state_q != S_IDLE && abort_i) ? S_IDLE :
              state_q == S_IDLE  ? (cmd_valid_i ? S_LOAD : S_IDLE) :
              state_q == S_LOAD  ? (cnt_zero ? S_CAPTURE : S_SHIFT) :
              state_q == S_SHIFT ? (cnt_one ? S_CAPTURE : S_SHIFT) : S_IDLE;
  always_comb begin
    cmd_ready_o = state_q == S_IDLE;
    busy_o      = state_q != S_IDLE;
    sr_load_o   = state_q == S_LOAD;
    sr_mode_o   = state_q == S_SHIFT ? (dir_q ? MODE_LSH : MODE_RSH) : MODE_HOLD;
  end
  always_comb begin
    data_d   = accept ? cmd_data_i : data_q;
    dir_d    = accept ? cmd_dir_i : dir_q;
    result_d = capture ? sr_q_i : result_q;
    flag_d   = capture ? sr_flag_i : flag_q;
    done_d   = capture;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q   <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      done_q   <= done_d;
    end
  assign sr_data_o = data_q;
  assign result_o  = result_q;
  assign flag_o    = flag_q;
  assign done_o    = done_q;
endmodule

// File: tb/tb_shift_controller.sv
// tb_shift_controller: scoreboard bench driving the controller against a ShiftRegister model
module tb_shift_controller;
  localparam int CW = 3;
  localparam int DW = 4;
  typedef struct {
    logic [DW-1:0] data;
    logic          dir;
    int            n;
    logic [DW-1:0] res;
    logic          flg;
    int            done_cyc;
  } exp_t;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
  logic [DW-1:0] cmd_data = '0;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_ready_o, sr_load_o, done_o, flag_o, busy_o;
  logic [1:0]    sr_mode_o;
  logic [DW-1:0] sr_data_o, result_o;
  logic [DW-1:0] sr_q = '0;
  logic          sr_f = 1'b0;
  int            cyc = 0, checks = 0, errors = 0, shifts = 0, last_wait = 0;
  logic          last_acc_done = 1'b0;
  exp_t          q[$];
  shift_controller #(.CNT_W(CW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready_o),
    .cmd_data_i (cmd_data),
    .cmd_dir_i  (cmd_dir),
    .cmd_count_i(cmd_count),
    .abort_i    (abort),
    .sr_load_o  (sr_load_o),
    .sr_mode_o  (sr_mode_o),
    .sr_data_o  (sr_data_o),
    .sr_q_i     (sr_q),
    .sr_flag_i  (sr_f),
    .done_o     (done_o),
    .result_o   (result_o),
    .flag_o     (flag_o),
    .busy_o     (busy_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // ALU ShiftRegister: zero fill, FLAG holds the last bit shifted out
  always @(posedge clk)
    if (sr_load_o) begin
      sr_q <= sr_data_o;
      sr_f <= 1'b0;
    end else if (sr_mode_o == 2'b10) {sr_f, sr_q} <= {sr_q, 1'b0};
    else if (sr_mode_o == 2'b01) {sr_q, sr_f} <= {1'b0, sr_q};
  function automatic exp_t model(input logic [DW-1:0] d, input logic dir, input int n);
    exp_t e;
    int v = int'(d);
    e.data = d;
    e.dir  = dir;
    e.n    = n;
    e.res  = DW'(dir ? (v << n) : (v >> n));
    if (n == 0 || n > DW) e.flg = 1'b0;
    else e.flg = dir ? 1'(v >> (DW - n)) : 1'(v >> (n - 1));
    e.done_cyc = 0;
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, cmd_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_sr_load"}, sr_load_o, 0);
    chk({tag, "_sr_mode"}, sr_mode_o, 0);
    chk({tag, "_sr_data"}, sr_data_o, 0);
    chk({tag, "_result"}, result_o, 0);
    chk({tag, "_flag"}, flag_o, 0);
  endtask
  task automatic send(input logic [DW-1:0] d, input logic dir, input int n, input bit track);
    int w = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_count = CW'(n);
    while (!cmd_ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready stuck low after %0d cycles", w);
      return;
    end
    last_wait     = w;
    last_acc_done = done_o;
    if (track) begin
      e = model(d, dir, n);
      e.done_cyc = cyc + 3 + n;
      q.push_back(e);
    end
    @(negedge clk);
  endtask
  task automatic idle();
    cmd_valid = 1'b0;
  endtask
  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
    end
    @(negedge clk);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      exp_t e;
      if (sr_load_o) begin
        shifts = 0;
        if (q.size() != 0) chk("sr_data", sr_data_o, q[0].data);
      end
      if (sr_mode_o != 2'b00) begin
        shifts++;
        if (q.size() != 0) chk("sr_mode", sr_mode_o, q[0].dir ? 2'b10 : 2'b01);
      end
      if (done_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("result", result_o, e.res);
          chk("flag_out", flag_o, e.flg);
          chk("shift_cycles", shifts, e.n);
          chk("done_cycle", cyc, e.done_cyc);
        end
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    exp_t m;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    send(4'b1101, 1'b0, 2, 1'b1);
    idle();
    drain();
    chk("r036_result", result_o, 4'b0011);
    send(4'b1001, 1'b1, 0, 1'b1);
    idle();
    drain();
    chk("r037_result", result_o, 4'b1001);
    send(4'b1000, 1'b0, 3, 1'b1);
    send(4'b0001, 1'b1, 1, 1'b1);
    chk("b2b_accept_in_done", last_acc_done, 1);
    idle();
    drain();
    chk("r038_result", result_o, 4'b0010);
    abort = 1'b1;
    send(4'b1010, 1'b0, 1, 1'b1);
    abort = 1'b0;
    idle();
    drain();
    m = model(4'b1010, 1'b0, 1);
    chk("idle_abort_result", result_o, m.res);
    send(4'b0110, 1'b0, 5, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_ready", cmd_ready_o, 1);
    chk("abort_done", done_o, 0);
    repeat (4) @(negedge clk);
    chk("abort_result_kept", result_o, m.res);
    chk("abort_flag_kept", flag_o, m.flg);
    send(4'b0111, 1'b1, 6, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", busy_o, 1);
    #3 rst_n = 1'b0;
    #1 check_reset_values("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send(4'b0101, 1'b1, 2, 1'b1);
    chk("accept_after_reset_wait", last_wait, 0);
    idle();
    drain();
    for (int i = 0; i < 40; i++) begin
      send(DW'($urandom), 1'($urandom), int'($urandom_range(0, 7)), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    idle();
    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
